// File: rtl/large_integer_accumulate_to_float.sv
// Exact wide accumulation of 279-bit fixed-point terms (bit k weighs 2^(k-150)), converted to binary32 at group end.
// Optional build macro: LARGE_ACC_ROUND_NEAREST_EN selects round-to-nearest-even instead of truncation.
module large_integer_accumulate_to_float #(
  parameter int ACC_W       = 290,
  parameter int COARSE_STEP = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic         in_last_i,
  input  logic [278:0] in_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [31:0]  out_o,
  output logic         ovf_o
);

  localparam int IN_W = 279;
  localparam int MSB  = ACC_W - 1;
  localparam int SC_W = $clog2(ACC_W + 1);
  localparam logic [SC_W-1:0]   SC_COARSE = SC_W'(COARSE_STEP);
  localparam logic [SC_W-1:0]   SC_ONE    = SC_W'(1);
  localparam logic signed [10:0] E_TOP    = 11'(ACC_W - 24);

  typedef enum logic [2:0] {
    ST_ACCUM  = 3'd0,
    ST_ABS    = 3'd1,
    ST_COARSE = 3'd2,
    ST_FINE   = 3'd3,
    ST_ROUND  = 3'd4,
    ST_OUT    = 3'd5
  } state_t;

  state_t            state_r;
  state_t            state_nxt_s;
  logic [ACC_W-1:0]  acc_r;
  logic              ovf_flag_r;
  logic              sign_r;
  logic              zero_r;
  logic [ACC_W-1:0]  mag_r;
  logic [SC_W-1:0]   sc_r;
  logic              in_ready_r;
  logic              out_valid_r;
  logic [31:0]       out_r;
  logic              ovf_out_r;

  logic [ACC_W-1:0]  in_ext_s;
  logic [ACC_W-1:0]  sum_s;
  logic              add_ovf_s;
  logic              take_s;
  logic              acc_zero_s;
  logic              coarse_hit_s;
  logic signed [10:0] e_s;
  logic signed [10:0] e_rnd_s;
  logic [22:0]       mant_s;
  logic [23:0]       mant_rnd_s;
  logic              inc_s;
  logic [31:0]       result_s;

  assign in_ext_s     = {{(ACC_W-IN_W){in_i[IN_W-1]}}, in_i};
  assign sum_s        = acc_r + in_ext_s;
  assign add_ovf_s    = (acc_r[MSB] == in_ext_s[MSB]) && (sum_s[MSB] != acc_r[MSB]);
  assign take_s       = in_valid_i && in_ready_r;
  assign acc_zero_s   = (acc_r == {ACC_W{1'b0}});
  assign coarse_hit_s = |mag_r[MSB -: COARSE_STEP];

  // Normalised magnitude has its leading one at MSB; the exponent falls out of the shift count.
  assign e_s    = E_TOP - $signed({{(11-SC_W){1'b0}}, sc_r});
  assign mant_s = mag_r[ACC_W-2 -: 23];

`ifdef LARGE_ACC_ROUND_NEAREST_EN
  logic guard_s;
  logic sticky_s;
  assign guard_s  = mag_r[ACC_W-25];
  assign sticky_s = |mag_r[ACC_W-26:0];
  assign inc_s    = guard_s && (sticky_s || mant_s[0]);
`else
  assign inc_s    = 1'b0;
`endif

  assign mant_rnd_s = {1'b0, mant_s} + {23'd0, inc_s};
  assign e_rnd_s    = mant_rnd_s[23] ? (e_s + 11'sd1) : e_s;

  // Result encoding with overflow, zero, infinity and flush cases in priority order.
  always_comb begin
    result_s = 32'h0000_0000;
    if (ovf_flag_r) begin
      result_s = 32'h7FC0_0000;
    end else if (zero_r) begin
      result_s = 32'h0000_0000;
    end else if (e_rnd_s >= 11'sd255) begin
      result_s = {sign_r, 8'hFF, 23'h000000};
    end else if (e_rnd_s <= 11'sd0) begin
      result_s = {sign_r, 31'h0000_0000};
    end else begin
      result_s = {sign_r, e_rnd_s[7:0], mant_rnd_s[22:0]};
    end
  end

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r <= ST_ACCUM;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_ACCUM:  if (take_s && in_last_i) state_nxt_s = ST_ABS;    else state_nxt_s = ST_ACCUM;
      ST_ABS:    if (acc_zero_s)          state_nxt_s = ST_ROUND;  else state_nxt_s = ST_COARSE;
      ST_COARSE: if (coarse_hit_s)        state_nxt_s = ST_FINE;   else state_nxt_s = ST_COARSE;
      ST_FINE:   if (mag_r[MSB])          state_nxt_s = ST_ROUND;  else state_nxt_s = ST_FINE;
      ST_ROUND:  state_nxt_s = ST_OUT;
      ST_OUT:    if (out_ready_i)         state_nxt_s = ST_ACCUM;  else state_nxt_s = ST_OUT;
      default:   state_nxt_s = ST_ACCUM;
    endcase
  end

  // Handshake flags registered from the next state so they line up with it.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      in_ready_r  <= (state_nxt_s == ST_ACCUM);
      out_valid_r <= (state_nxt_s == ST_OUT);
    end
  end

  // Accumulate, take magnitude, normalise and capture the rounded result.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      acc_r      <= {ACC_W{1'b0}};
      ovf_flag_r <= 1'b0;
      sign_r     <= 1'b0;
      zero_r     <= 1'b0;
      mag_r      <= {ACC_W{1'b0}};
      sc_r       <= {SC_W{1'b0}};
      out_r      <= 32'h0000_0000;
      ovf_out_r  <= 1'b0;
    end else begin
      case (state_r)
        ST_ACCUM: begin
          if (take_s) begin
            acc_r <= sum_s;
            if (add_ovf_s) ovf_flag_r <= 1'b1;
          end
        end
        ST_ABS: begin
          sign_r <= acc_r[MSB];
          zero_r <= acc_zero_s;
          mag_r  <= acc_r[MSB] ? -acc_r : acc_r;
          sc_r   <= {SC_W{1'b0}};
        end
        ST_COARSE: begin
          if (!coarse_hit_s) begin
            mag_r <= mag_r << COARSE_STEP;
            sc_r  <= sc_r + SC_COARSE;
          end
        end
        ST_FINE: begin
          if (!mag_r[MSB]) begin
            mag_r <= mag_r << 1;
            sc_r  <= sc_r + SC_ONE;
          end
        end
        ST_ROUND: begin
          out_r     <= result_s;
          ovf_out_r <= ovf_flag_r;
        end
        ST_OUT: begin
          if (out_ready_i) begin
            acc_r      <= {ACC_W{1'b0}};
            ovf_flag_r <= 1'b0;
            ovf_out_r  <= 1'b0;
          end
        end
        default: begin
          acc_r <= acc_r;
        end
      endcase
    end
  end

  assign in_ready_o  = in_ready_r;
  assign out_valid_o = out_valid_r;
  assign out_o       = out_r;
  assign ovf_o       = ovf_out_r;

endmodule
